// File: rtl/sd_bram_block_be.sv
// True dual-port block RAM for the SD data path. It supports byte write enables,
// a selectable read-during-write mode, an optional output stage and a clear sequencer.
module sd_bram_block_be #(
    parameter int DATA           = 32,
    parameter int ADDR           = 7,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              busy,
    input  logic              a_en,
    input  logic [DATA/8-1:0] a_we,
    input  logic [ADDR-1:0]   a_addr,
    input  logic [DATA-1:0]   a_din,
    output logic [DATA-1:0]   a_dout,
    output logic              a_valid,
    input  logic              b_en,
    input  logic [DATA/8-1:0] b_we,
    input  logic [ADDR-1:0]   b_addr,
    input  logic [DATA-1:0]   b_din,
    output logic [DATA-1:0]   b_dout,
    output logic              b_valid,
    output logic              collision
);

    localparam int LANES = DATA / 8;
    localparam int DEPTH = 1 << ADDR;
    localparam logic [ADDR:0] CLR_LAST = (ADDR+1)'(DEPTH - 1);
    localparam logic [ADDR:0] CLR_ONE  = (ADDR+1)'(1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t          state, state_next;
    logic [ADDR:0]   clr_cnt, clr_cnt_next;
    logic [DATA-1:0] mem [DEPTH];
    logic            a_acc, b_acc;
    logic [DATA-1:0] a_rd, b_rd;
    logic [DATA-1:0] a_q1, b_q1;
    logic            a_v1, b_v1;

    assign busy  = (state == ST_CLEAR);
    assign a_acc = a_en && !busy;
    assign b_acc = b_en && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RESET;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            ST_IDLE: begin
                if (clr_start) begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_next   = ST_IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt + CLR_ONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Port A is written after port B so that A wins any lane both ports enable.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt[ADDR-1:0]] <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (b_acc && b_we[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
                if (a_acc && a_we[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
            end
        end
    end

    // Cross-port reads always see the pre-edge word; only a port's own lanes merge in.
    always_comb begin
        a_rd = mem[a_addr];
        b_rd = mem[b_addr];
        if (RDW_MODE == 0) begin
            for (int i = 0; i < LANES; i++) begin
                if (a_we[i]) a_rd[8*i +: 8] = a_din[8*i +: 8];
                if (b_we[i]) b_rd[8*i +: 8] = b_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q1      <= '0;
            b_q1      <= '0;
            a_v1      <= 1'b0;
            b_v1      <= 1'b0;
            collision <= 1'b0;
        end else begin
            a_v1      <= a_acc;
            b_v1      <= b_acc;
            collision <= a_acc && b_acc && (a_addr == b_addr) && (|a_we) && (|b_we);
            if (a_acc) a_q1 <= a_rd;
            if (b_acc) b_q1 <= b_rd;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA-1:0] a_q2, b_q2;
            logic            a_v2, b_v2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q2 <= '0;
                    b_q2 <= '0;
                    a_v2 <= 1'b0;
                    b_v2 <= 1'b0;
                end else begin
                    a_v2 <= a_v1;
                    b_v2 <= b_v1;
                    if (a_v1) a_q2 <= a_q1;
                    if (b_v1) b_q2 <= b_q1;
                end
            end

            assign a_dout  = a_q2;
            assign b_dout  = b_q2;
            assign a_valid = a_v2;
            assign b_valid = b_v2;
        end else begin : g_no_out_reg
            assign a_dout  = a_q1;
            assign b_dout  = b_q1;
            assign a_valid = a_v1;
            assign b_valid = b_v1;
        end
    endgenerate

endmodule
